lcd_spi_sink: RTL and testbench

LCD_SPI_SINK -- requirements
Module: lcd_spi_sink

---
 rtl/lcd_spi_sink_pkg.sv | 21 ++
 rtl/lcd_spi_byte_rx.sv | 94 +++++++++
 rtl/lcd_spi_sink.sv | 202 ++++++++++++++++++++
 tb/tb_lcd_spi_sink.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/lcd_spi_sink_pkg.sv
// rtl/lcd_spi_sink_pkg.sv - command codes, decoder states and window helper for lcd_spi_sink
package lcd_spi_sink_pkg;

  localparam logic [7:0] CMD_CASET = 8'h2A;
  localparam logic [7:0] CMD_RASET = 8'h2B;
  localparam logic [7:0] CMD_RAMWR = 8'h2C;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CASET_P = 3'd1,
    ST_RASET_P = 3'd2,
    ST_RAMWR   = 3'd3,
    ST_SKIP    = 3'd4
  } state_e;

  function automatic logic win_ok(input logic [15:0] start, input logic [15:0] stop,
                                  input logic [31:0] dim);
    return (start <= stop) && ({16'd0, stop} < dim);
  endfunction

endpackage

// File: rtl/lcd_spi_byte_rx.sv
// rtl/lcd_spi_byte_rx.sv - pin synchronisers and SPI mode-0 byte deserialiser
module lcd_spi_byte_rx (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       lcd_spi_sclk,
  input  logic       lcd_spi_mosi,
  input  logic       lcd_spi_cs,
  input  logic       lcd_dc,
  input  logic       lcd_reset,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       byte_dc,
  output logic       err,
  output logic       panel_rst_n
);

  // Bit order in the synchroniser vectors: {lcd_reset, dc, cs, mosi, sclk}
  localparam logic [4:0] SYNC_RST = 5'b10100;

  logic [4:0] meta_q, meta_d, sync_q, sync_d;
  logic       sclk_last_q, sclk_last_d, cs_last_q, cs_last_d;
  logic [6:0] shift_q, shift_d;
  logic [2:0] cnt_q, cnt_d;
  logic       byte_valid_q, byte_valid_d, byte_dc_q, byte_dc_d, err_q, err_d;
  logic [7:0] byte_data_q, byte_data_d;
  logic       sclk_rise, cs_rise, sample;

  always_comb begin
    meta_d       = {lcd_reset, lcd_dc, lcd_spi_cs, lcd_spi_mosi, lcd_spi_sclk};
    sync_d       = meta_q;
    sclk_last_d  = sync_q[0];
    cs_last_d    = sync_q[2];
    sclk_rise    = sync_q[0] & ~sclk_last_q;
    cs_rise      = sync_q[2] & ~cs_last_q;
    // An sclk edge that lands together with the cs rise still belongs to the byte
    sample       = sclk_rise & (~sync_q[2] | cs_rise);
    shift_d      = shift_q;
    cnt_d        = cnt_q;
    byte_valid_d = 1'b0;
    byte_data_d  = byte_data_q;
    byte_dc_d    = byte_dc_q;
    err_d        = 1'b0;
    if (!sync_q[4]) begin
      cnt_d = 3'd0;
    end else begin
      if (sample) begin
        shift_d = {shift_q[5:0], sync_q[1]};
        cnt_d   = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          byte_valid_d = 1'b1;
          byte_data_d  = {shift_q, sync_q[1]};
          byte_dc_d    = sync_q[3];
        end
      end
      if (cs_rise) begin
        err_d = (cnt_d != 3'd0);
        cnt_d = 3'd0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q       <= SYNC_RST;
      sync_q       <= SYNC_RST;
      sclk_last_q  <= 1'b0;
      cs_last_q    <= 1'b1;
      shift_q      <= '0;
      cnt_q        <= '0;
      byte_valid_q <= 1'b0;
      byte_data_q  <= '0;
      byte_dc_q    <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      meta_q       <= meta_d;
      sync_q       <= sync_d;
      sclk_last_q  <= sclk_last_d;
      cs_last_q    <= cs_last_d;
      shift_q      <= shift_d;
      cnt_q        <= cnt_d;
      byte_valid_q <= byte_valid_d;
      byte_data_q  <= byte_data_d;
      byte_dc_q    <= byte_dc_d;
      err_q        <= err_d;
    end
  end

  assign byte_valid  = byte_valid_q;
  assign byte_data   = byte_data_q;
  assign byte_dc     = byte_dc_q;
  assign err         = err_q;
  assign panel_rst_n = sync_q[4];

endmodule

// File: rtl/lcd_spi_sink.sv
// rtl/lcd_spi_sink.sv - LCD SPI command decoder: address window, RAMWR pixel stream
module lcd_spi_sink
  import lcd_spi_sink_pkg::*;
#(
  parameter logic [31:0] SCREEN_WIDTH  = 32'd240,
  parameter logic [31:0] SCREEN_HEIGHT = 32'd240
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        lcd_spi_sclk,
  input  logic        lcd_spi_mosi,
  input  logic        lcd_spi_cs,
  input  logic        lcd_dc,
  input  logic        lcd_reset,
  output logic        byte_valid,
  output logic [7:0]  byte_data,
  output logic        byte_dc,
  output logic        cmd_valid,
  output logic        pix_valid,
  output logic [15:0] pix_x,
  output logic [15:0] pix_y,
  output logic [15:0] pix_data,
  output logic        frame_done,
  output logic        err
);

  localparam logic [15:0] XMAX = 16'(SCREEN_WIDTH - 32'd1);
  localparam logic [15:0] YMAX = 16'(SCREEN_HEIGHT - 32'd1);

  logic        rx_err, panel_rst_n;
  state_e      state_q, state_d;
  logic [1:0]  pcnt_q, pcnt_d;
  logic [23:0] pbuf_q, pbuf_d;
  logic [15:0] xs_q, xs_d, xe_q, xe_d, ys_q, ys_d, ye_q, ye_d;
  logic [15:0] ptr_x_q, ptr_x_d, ptr_y_q, ptr_y_d;
  logic        phase_q, phase_d;
  logic [7:0]  hi_q, hi_d;
  logic        cmd_valid_q, cmd_valid_d, pix_valid_q, pix_valid_d;
  logic        frame_done_q, frame_done_d, err_q, err_d;
  logic [15:0] pix_x_q, pix_x_d, pix_y_q, pix_y_d, pix_data_q, pix_data_d;
  logic [15:0] p_start, p_end;

  lcd_spi_byte_rx u_rx (
    .clk         (clk),
    .rst_n       (rst_n),
    .lcd_spi_sclk(lcd_spi_sclk),
    .lcd_spi_mosi(lcd_spi_mosi),
    .lcd_spi_cs  (lcd_spi_cs),
    .lcd_dc      (lcd_dc),
    .lcd_reset   (lcd_reset),
    .byte_valid  (byte_valid),
    .byte_data   (byte_data),
    .byte_dc     (byte_dc),
    .err         (rx_err),
    .panel_rst_n (panel_rst_n)
  );

  always_comb begin
    state_d      = state_q;
    pcnt_d       = pcnt_q;
    pbuf_d       = pbuf_q;
    xs_d         = xs_q;
    xe_d         = xe_q;
    ys_d         = ys_q;
    ye_d         = ye_q;
    ptr_x_d      = ptr_x_q;
    ptr_y_d      = ptr_y_q;
    phase_d      = phase_q;
    hi_d         = hi_q;
    cmd_valid_d  = 1'b0;
    pix_valid_d  = 1'b0;
    frame_done_d = 1'b0;
    err_d        = rx_err;
    pix_x_d      = pix_x_q;
    pix_y_d      = pix_y_q;
    pix_data_d   = pix_data_q;
    p_start      = pbuf_q[23:8];
    p_end        = {pbuf_q[7:0], byte_data};
    if (!panel_rst_n) begin
      state_d = ST_IDLE;
      xs_d    = '0;
      xe_d    = XMAX;
      ys_d    = '0;
      ye_d    = YMAX;
      ptr_x_d = '0;
      ptr_y_d = '0;
      phase_d = 1'b0;
      pcnt_d  = '0;
    end else if (byte_valid && !byte_dc) begin
      // Any command drops an odd RAMWR byte or unfinished parameter list
      cmd_valid_d = 1'b1;
      phase_d     = 1'b0;
      pcnt_d      = '0;
      case (byte_data)
        CMD_CASET: state_d = ST_CASET_P;
        CMD_RASET: state_d = ST_RASET_P;
        CMD_RAMWR: begin
          state_d = ST_RAMWR;
          ptr_x_d = xs_q;
          ptr_y_d = ys_q;
        end
        default:   state_d = ST_SKIP;
      endcase
    end else if (byte_valid) begin
      case (state_q)
        ST_CASET_P, ST_RASET_P: begin
          pcnt_d = pcnt_q + 2'd1;
          pbuf_d = {pbuf_q[15:0], byte_data};
          if (pcnt_q == 2'd3) begin
            state_d = ST_SKIP;
            if (state_q == ST_CASET_P) begin
              if (win_ok(p_start, p_end, SCREEN_WIDTH)) begin
                xs_d = p_start;
                xe_d = p_end;
              end else begin
                err_d = 1'b1;
              end
            end else if (win_ok(p_start, p_end, SCREEN_HEIGHT)) begin
              ys_d = p_start;
              ye_d = p_end;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        ST_RAMWR: begin
          phase_d = ~phase_q;
          if (!phase_q) begin
            hi_d = byte_data;
          end else begin
            pix_valid_d = 1'b1;
            pix_x_d     = ptr_x_q;
            pix_y_d     = ptr_y_q;
            pix_data_d  = {hi_q, byte_data};
            if (ptr_x_q < xe_q) begin
              ptr_x_d = ptr_x_q + 16'd1;
            end else if (ptr_y_q < ye_q) begin
              ptr_x_d = xs_q;
              ptr_y_d = ptr_y_q + 16'd1;
            end else begin
              frame_done_d = 1'b1;
              ptr_x_d      = xs_q;
              ptr_y_d      = ys_q;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      pcnt_q       <= '0;
      pbuf_q       <= '0;
      xs_q         <= '0;
      xe_q         <= XMAX;
      ys_q         <= '0;
      ye_q         <= YMAX;
      ptr_x_q      <= '0;
      ptr_y_q      <= '0;
      phase_q      <= 1'b0;
      hi_q         <= '0;
      cmd_valid_q  <= 1'b0;
      pix_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
      pix_x_q      <= '0;
      pix_y_q      <= '0;
      pix_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      pcnt_q       <= pcnt_d;
      pbuf_q       <= pbuf_d;
      xs_q         <= xs_d;
      xe_q         <= xe_d;
      ys_q         <= ys_d;
      ye_q         <= ye_d;
      ptr_x_q      <= ptr_x_d;
      ptr_y_q      <= ptr_y_d;
      phase_q      <= phase_d;
      hi_q         <= hi_d;
      cmd_valid_q  <= cmd_valid_d;
      pix_valid_q  <= pix_valid_d;
      frame_done_q <= frame_done_d;
      err_q        <= err_d;
      pix_x_q      <= pix_x_d;
      pix_y_q      <= pix_y_d;
      pix_data_q   <= pix_data_d;
    end
  end

  assign cmd_valid  = cmd_valid_q;
  assign pix_valid  = pix_valid_q;
  assign frame_done = frame_done_q;
  assign err        = err_q;
  assign pix_x      = pix_x_q;
  assign pix_y      = pix_y_q;
  assign pix_data   = pix_data_q;

endmodule

// File: tb/tb_lcd_spi_sink.sv
// tb/tb_lcd_spi_sink.sv - directed scoreboard bench for lcd_spi_sink on a 3x4 panel
module tb_lcd_spi_sink;

  logic        clk = 1'b0;
  logic        rst_n, sclk, mosi, cs, dc, lcd_reset;
  logic        byte_valid, byte_dc, cmd_valid, pix_valid, frame_done, err;
  logic [7:0]  byte_data;
  logic [15:0] pix_x, pix_y, pix_data;

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] d;
    logic        fd;
  } px_t;

  px_t  exp_q[$];
  px_t  e;
  int   n_checks = 0, n_fail = 0, cyc = 0;
  int   byte_cnt = 0, cmd_cnt = 0, err_cnt = 0, last_byte_cyc = 0, bit8_cyc = 0;
  logic [7:0] last_byte = '0;
  logic last_dc = 1'b0, bv_prev = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  lcd_spi_sink #(.SCREEN_WIDTH(32'd3), .SCREEN_HEIGHT(32'd4)) dut (
    .clk(clk), .rst_n(rst_n), .lcd_spi_sclk(sclk), .lcd_spi_mosi(mosi), .lcd_spi_cs(cs),
    .lcd_dc(dc), .lcd_reset(lcd_reset), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_dc(byte_dc), .cmd_valid(cmd_valid), .pix_valid(pix_valid), .pix_x(pix_x),
    .pix_y(pix_y), .pix_data(pix_data), .frame_done(frame_done), .err(err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (byte_valid) begin
        byte_cnt++;
        last_byte     = byte_data;
        last_dc       = byte_dc;
        last_byte_cyc = cyc;
      end
      if (cmd_valid) cmd_cnt++;
      if (err) err_cnt++;
      if (frame_done) chk("fd_with_pix", pix_valid, 1);
      if (pix_valid) begin
        chk("pix_lat", bv_prev, 1);
        if (exp_q.size() == 0) chk("pix_extra", exp_q.size(), 1);
        else begin
          e = exp_q.pop_front();
          chk("pix", {pix_x, pix_y, pix_data, frame_done}, {e.x, e.y, e.d, e.fd});
        end
      end
    end
    bv_prev = byte_valid;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bits(input logic [7:0] b, input int n, input logic d);
    cs = 1'b0;
    dc = d;
    for (int i = 7; i > 7 - n; i--) begin
      sclk = 1'b0;
      mosi = b[i];
      wait_clk(2);
      sclk = 1'b1;
      bit8_cyc = cyc;
      wait_clk(2);
    end
    sclk = 1'b0;
    wait_clk(2);
    cs = 1'b1;
    wait_clk(6);
  endtask

  task automatic send_cmd(input logic [7:0] b);
    send_bits(b, 8, 1'b0);
  endtask

  task automatic send_data(input logic [7:0] b);
    send_bits(b, 8, 1'b1);
  endtask

  task automatic push_px(input int x, input int y, input logic [15:0] d, input logic fd);
    px_t p;
    p.x  = 16'(x);
    p.y  = 16'(y);
    p.d  = d;
    p.fd = fd;
    exp_q.push_back(p);
  endtask

  task automatic send_px(input int x, input int y, input logic fd);
    logic [7:0] hb, lb;
    hb = 8'($urandom_range(0, 255));
    lb = 8'($urandom_range(0, 255));
    push_px(x, y, {hb, lb}, fd);
    send_data(hb);
    send_data(lb);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) wait_clk(1);
    chk(tag, exp_q.size(), 0);
  endtask

  task automatic send_window(input logic [7:0] c, input logic [15:0] s, input logic [15:0] t);
    send_cmd(c);
    send_data(s[15:8]);
    send_data(s[7:0]);
    send_data(t[15:8]);
    send_data(t[7:0]);
  endtask

  int e0, b0, c0;

  initial begin
    rst_n = 1'b0; sclk = 1'b0; mosi = 1'b0; cs = 1'b1; dc = 1'b0; lcd_reset = 1'b1;
    wait_clk(3);
    chk("rst_out", {byte_valid, byte_data, byte_dc, cmd_valid, pix_valid, pix_x, pix_y,
                    pix_data, frame_done, err}, 0);
    rst_n = 1'b1;
    wait_clk(4);

    // full-screen frame
    send_cmd(8'h2C);
    for (int i = 0; i < 12; i++) send_px(i % 3, i / 3, i == 11);
    drain("frame_drain");
    chk("frame_cmds", cmd_cnt, 1);
    chk("frame_errs", err_cnt, 0);

    // out-of-range column window keeps the full screen
    e0 = err_cnt;
    send_window(8'h2A, 16'd2, 16'd5);
    chk("caset_err", err_cnt, e0 + 1);
    send_cmd(8'h2C);
    send_px(0, 0, 1'b0);
    drain("badwin_drain");

    // 2x2 window with wrap
    e0 = err_cnt;
    c0 = cmd_cnt;
    send_window(8'h2A, 16'd1, 16'd2);
    send_window(8'h2B, 16'd2, 16'd3);
    send_cmd(8'h2C);
    send_px(1, 2, 1'b0);
    send_px(2, 2, 1'b0);
    send_px(1, 3, 1'b0);
    send_px(2, 3, 1'b1);
    send_px(1, 2, 1'b0);
    drain("win_drain");
    chk("win_errs", err_cnt, e0);
    chk("win_cmds", cmd_cnt, c0 + 3);

    // truncated byte, then a clean byte
    e0 = err_cnt;
    b0 = byte_cnt;
    send_bits(8'hFF, 5, 1'b1);
    chk("trunc_err", err_cnt, e0 + 1);
    chk("trunc_nobyte", byte_cnt, b0);
    send_data(8'hA5);
    chk("a5_count", byte_cnt, b0 + 1);
    chk("a5_data", last_byte, 8'hA5);
    chk("a5_dc", last_dc, 1'b1);
    chk("a5_latency", last_byte_cyc - bit8_cyc, 3);

    // panel reset mid-pixel restores full screen
    send_cmd(8'h2C);
    send_data(8'h11);
    lcd_reset = 1'b0;
    wait_clk(6);
    lcd_reset = 1'b1;
    wait_clk(6);
    send_cmd(8'h2C);
    push_px(0, 0, 16'h1234, 1'b0);
    send_data(8'h12);
    send_data(8'h34);
    drain("lcdrst_drain");

    // system reset mid-frame
    send_window(8'h2A, 16'd1, 16'd2);
    send_window(8'h2B, 16'd2, 16'd3);
    send_cmd(8'h2C);
    send_px(1, 2, 1'b0);
    send_data(8'h77);
    drain("pre_rst_drain");
    rst_n = 1'b0;
    #1;
    chk("rst_mid", {byte_valid, byte_data, byte_dc, cmd_valid, pix_valid, pix_x, pix_y,
                    pix_data, frame_done, err}, 0);
    wait_clk(3);
    rst_n = 1'b1;
    wait_clk(4);
    send_cmd(8'h2C);
    send_px(0, 0, 1'b0);
    send_px(1, 0, 1'b0);
    send_px(2, 0, 1'b0);
    send_px(0, 1, 1'b0);
    drain("post_rst_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
